// File: rtl/riscv_defines.sv
// Shared types and constants for the core's execution sequencing.
package riscv_defines;

    localparam int RISCV_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        FETCH_WAIT,
        EXEC0,
        EXEC1,
        MEM_WAIT
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PC_SEL_INC,
        PC_SEL_ALU,
        PC_SEL_TRAP,
        PC_SEL_MEPC
    } pc_sel_t;

    localparam logic [RISCV_WORD_WIDTH-1:0] MCAUSE_ILLEGAL     = 32'd2;
    localparam logic [RISCV_WORD_WIDTH-1:0] MCAUSE_BREAKPOINT  = 32'd3;
    localparam logic [RISCV_WORD_WIDTH-1:0] MCAUSE_LOAD_FAULT  = 32'd5;
    localparam logic [RISCV_WORD_WIDTH-1:0] MCAUSE_STORE_FAULT = 32'd7;
    localparam logic [RISCV_WORD_WIDTH-1:0] MCAUSE_ECALL_M     = 32'd11;
    localparam logic [RISCV_WORD_WIDTH-1:0] MCAUSE_EXT_IRQ     = 32'h8000000B;

endpackage

// File: rtl/exec_trap_cause.sv
// Priority encoder for trap sources: interrupt, illegal, ECALL, EBREAK,
// then LSU timeout. Callers gate each source with the state it belongs to.
module exec_trap_cause
    import riscv_defines::*;
(
    input  logic                        irq_i,
    input  logic                        illegal_i,
    input  logic                        ecall_i,
    input  logic                        ebreak_i,
    input  logic                        lsu_timeout_i,
    input  logic                        lsu_store_i,
    output logic                        trap_o,
    output logic [RISCV_WORD_WIDTH-1:0] mcause_o
);

    // Highest-priority active source picks the cause.
    always_comb begin
        trap_o   = 1'b1;
        mcause_o = '0;
        if (irq_i)               mcause_o = MCAUSE_EXT_IRQ;
        else if (illegal_i)      mcause_o = MCAUSE_ILLEGAL;
        else if (ecall_i)        mcause_o = MCAUSE_ECALL_M;
        else if (ebreak_i)       mcause_o = MCAUSE_BREAKPOINT;
        else if (lsu_timeout_i)  mcause_o = lsu_store_i ? MCAUSE_STORE_FAULT
                                                        : MCAUSE_LOAD_FAULT;
        else                     trap_o   = 1'b0;
    end

endmodule

// File: rtl/exec_controller.sv
// Execution sequencing FSM: steps multi-cycle instructions, holds on LSU
// accesses, gates RF/PC writes and raises machine-mode traps.
// Optional interrupt path enabled by defining EXEC_IRQ_EN.
module exec_controller
    import riscv_defines::*;
#(
    parameter int unsigned LSU_TIMEOUT_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        instr_valid_i,
    output logic                        instr_ready_o,
    output logic                        cycle_counter_o,
    input  logic                        jump_inst_i,
    input  logic                        branch_inst_i,
    input  logic                        ecall_inst_i,
    input  logic                        ebreak_inst_i,
    input  logic                        mret_inst_i,
    input  logic                        illegal_inst_i,
    input  logic                        rf_we_i,
    input  logic                        lsu_r_en_i,
    input  logic                        lsu_w_en_i,
    input  logic                        branch_taken_i,
`ifdef EXEC_IRQ_EN
    input  logic                        irq_i,
    input  logic                        mie_i,
`endif
    output logic                        rf_we_o,
    output logic                        lsu_req_o,
    input  logic                        lsu_done_i,
    output logic                        pc_we_o,
    output pc_sel_t                     pc_sel_o,
    output logic                        mepc_we_o,
    output logic                        mcause_we_o,
    output logic [RISCV_WORD_WIDTH-1:0] mcause_o
);

    // Counter is wide enough that it never wraps before reaching the limit.
    localparam int TO_W = (LSU_TIMEOUT_CYCLES < 4) ? 2 : $clog2(LSU_TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST =
        (LSU_TIMEOUT_CYCLES == 0) ? '0 : TO_W'(LSU_TIMEOUT_CYCLES - 1);

    ctrl_state_t     state_q, state_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    logic                        irq_take;
    logic                        lsu_timeout;
    logic                        lsu_op;
    logic                        in_exec0;
    logic                        trap;
    logic [RISCV_WORD_WIDTH-1:0] trap_cause;

`ifdef EXEC_IRQ_EN
    assign irq_take = in_exec0 & irq_i & mie_i;
`else
    assign irq_take = 1'b0;
`endif

    assign in_exec0    = (state_q == EXEC0);
    assign lsu_op      = lsu_r_en_i | lsu_w_en_i;
    // Fires in the N-th MEM_WAIT cycle; a done in that cycle takes precedence.
    assign lsu_timeout = (LSU_TIMEOUT_CYCLES != 0) && (state_q == MEM_WAIT) &&
                         (to_cnt_q == TO_LAST) && !lsu_done_i;

    exec_trap_cause u_trap_cause (
        .irq_i         (irq_take),
        .illegal_i     (in_exec0 & illegal_inst_i),
        .ecall_i       (in_exec0 & ecall_inst_i),
        .ebreak_i      (in_exec0 & ebreak_inst_i),
        .lsu_timeout_i (lsu_timeout),
        .lsu_store_i   (lsu_w_en_i),
        .trap_o        (trap),
        .mcause_o      (trap_cause)
    );

    // State and timeout counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH_WAIT;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // Next-state and output decode; every enable defaults low.
    always_comb begin
        state_d         = state_q;
        to_cnt_d        = '0;
        instr_ready_o   = 1'b0;
        cycle_counter_o = 1'b0;
        rf_we_o         = 1'b0;
        lsu_req_o       = 1'b0;
        pc_we_o         = 1'b0;
        pc_sel_o        = PC_SEL_INC;
        mepc_we_o       = 1'b0;
        mcause_we_o     = 1'b0;
        mcause_o        = '0;

        unique case (state_q)
            FETCH_WAIT: begin
                if (instr_valid_i) state_d = EXEC0;
            end

            EXEC0: begin
                if (trap) begin
                    // Interrupts leave the instruction unretired so it reruns after MRET.
                    mepc_we_o     = 1'b1;
                    mcause_we_o   = 1'b1;
                    pc_we_o       = 1'b1;
                    pc_sel_o      = PC_SEL_TRAP;
                    mcause_o      = trap_cause;
                    instr_ready_o = !irq_take;
                    state_d       = FETCH_WAIT;
                end else if (mret_inst_i) begin
                    pc_we_o       = 1'b1;
                    pc_sel_o      = PC_SEL_MEPC;
                    instr_ready_o = 1'b1;
                    state_d       = FETCH_WAIT;
                end else if (jump_inst_i) begin
                    rf_we_o = 1'b1;
                    state_d = EXEC1;
                end else if (branch_inst_i) begin
                    if (branch_taken_i) begin
                        state_d = EXEC1;
                    end else begin
                        pc_we_o       = 1'b1;
                        instr_ready_o = 1'b1;
                        state_d       = FETCH_WAIT;
                    end
                end else if (lsu_op) begin
                    lsu_req_o = 1'b1;
                    if (lsu_done_i) begin
                        rf_we_o       = lsu_r_en_i;
                        pc_we_o       = 1'b1;
                        instr_ready_o = 1'b1;
                        state_d       = FETCH_WAIT;
                    end else begin
                        state_d = MEM_WAIT;
                    end
                end else begin
                    rf_we_o       = rf_we_i;
                    pc_we_o       = 1'b1;
                    instr_ready_o = 1'b1;
                    state_d       = FETCH_WAIT;
                end
            end

            EXEC1: begin
                cycle_counter_o = 1'b1;
                pc_we_o         = 1'b1;
                pc_sel_o        = PC_SEL_ALU;
                instr_ready_o   = 1'b1;
                state_d         = FETCH_WAIT;
            end

            MEM_WAIT: begin
                if (lsu_done_i) begin
                    lsu_req_o     = 1'b1;
                    rf_we_o       = lsu_r_en_i;
                    pc_we_o       = 1'b1;
                    instr_ready_o = 1'b1;
                    state_d       = FETCH_WAIT;
                end else if (trap) begin
                    mepc_we_o     = 1'b1;
                    mcause_we_o   = 1'b1;
                    pc_we_o       = 1'b1;
                    pc_sel_o      = PC_SEL_TRAP;
                    mcause_o      = trap_cause;
                    instr_ready_o = 1'b1;
                    state_d       = FETCH_WAIT;
                end else begin
                    lsu_req_o = 1'b1;
                    to_cnt_d  = to_cnt_q + 1'b1;
                end
            end

            default: state_d = FETCH_WAIT;
        endcase
    end

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller (LSU timeout of 4 cycles).
module tb_exec_controller;
    import riscv_defines::*;

    logic        clk, rst_n;
    logic        instr_valid_i, instr_ready_o, cycle_counter_o;
    logic        jump_inst_i, branch_inst_i, ecall_inst_i, ebreak_inst_i;
    logic        mret_inst_i, illegal_inst_i, rf_we_i, lsu_r_en_i, lsu_w_en_i;
    logic        branch_taken_i, rf_we_o, lsu_req_o, lsu_done_i, pc_we_o;
    pc_sel_t     pc_sel_o;
    logic        mepc_we_o, mcause_we_o;
    logic [31:0] mcause_o;
`ifdef EXEC_IRQ_EN
    logic        irq_i, mie_i;
`endif

    int checks = 0;
    int failures = 0;

    exec_controller #(.LSU_TIMEOUT_CYCLES(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_valid_i   (instr_valid_i),
        .instr_ready_o   (instr_ready_o),
        .cycle_counter_o (cycle_counter_o),
        .jump_inst_i     (jump_inst_i),
        .branch_inst_i   (branch_inst_i),
        .ecall_inst_i    (ecall_inst_i),
        .ebreak_inst_i   (ebreak_inst_i),
        .mret_inst_i     (mret_inst_i),
        .illegal_inst_i  (illegal_inst_i),
        .rf_we_i         (rf_we_i),
        .lsu_r_en_i      (lsu_r_en_i),
        .lsu_w_en_i      (lsu_w_en_i),
        .branch_taken_i  (branch_taken_i),
`ifdef EXEC_IRQ_EN
        .irq_i           (irq_i),
        .mie_i           (mie_i),
`endif
        .rf_we_o         (rf_we_o),
        .lsu_req_o       (lsu_req_o),
        .lsu_done_i      (lsu_done_i),
        .pc_we_o         (pc_we_o),
        .pc_sel_o        (pc_sel_o),
        .mepc_we_o       (mepc_we_o),
        .mcause_we_o     (mcause_we_o),
        .mcause_o        (mcause_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_o(input string tag, input logic rdy, input logic rf, input logic pcw,
                         input logic [1:0] sel, input logic req, input logic cc,
                         input logic mw, input logic cw, input logic [31:0] cause);
        chk({tag, ".ready"},  32'(instr_ready_o),   32'(rdy));
        chk({tag, ".rf_we"},  32'(rf_we_o),         32'(rf));
        chk({tag, ".pc_we"},  32'(pc_we_o),         32'(pcw));
        chk({tag, ".pc_sel"}, 32'(pc_sel_o),        32'(sel));
        chk({tag, ".lsu_req"},32'(lsu_req_o),       32'(req));
        chk({tag, ".cyc"},    32'(cycle_counter_o), 32'(cc));
        chk({tag, ".mepc_we"},32'(mepc_we_o),       32'(mw));
        chk({tag, ".mc_we"},  32'(mcause_we_o),     32'(cw));
        chk({tag, ".mcause"}, mcause_o,             cause);
    endtask

    task automatic idle(input string tag);
        exp_o(tag, 0, 0, 0, PC_SEL_INC, 0, 0, 0, 0, 32'd0);
    endtask

    task automatic nx();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; instr_valid_i = 0; jump_inst_i = 0; branch_inst_i = 0;
        ecall_inst_i = 0; ebreak_inst_i = 0; mret_inst_i = 0; illegal_inst_i = 0;
        rf_we_i = 0; lsu_r_en_i = 0; lsu_w_en_i = 0; branch_taken_i = 0; lsu_done_i = 0;
`ifdef EXEC_IRQ_EN
        irq_i = 0; mie_i = 0;
`endif
        repeat (2) nx();
        #1 idle("reset");
        chk("reset.state", 32'(dut.state_q), 32'(FETCH_WAIT));
        rst_n = 1'b1;

        // ADDI back-to-back: retire every 2 cycles
        nx(); instr_valid_i = 1; rf_we_i = 1; #1 idle("addi_fw");
        nx(); #1 exp_o("addi_e0", 1, 1, 1, PC_SEL_INC, 0, 0, 0, 0, 0);
        nx(); #1 idle("addi2_fw");
        nx(); #1 exp_o("addi2_e0", 1, 1, 1, PC_SEL_INC, 0, 0, 0, 0, 0);

        // JAL: link then target
        nx(); rf_we_i = 0; jump_inst_i = 1; #1 idle("jal_fw");
        nx(); #1 exp_o("jal_e0", 0, 1, 0, PC_SEL_INC, 0, 0, 0, 0, 0);
        nx(); #1 exp_o("jal_e1", 1, 0, 1, PC_SEL_ALU, 0, 1, 0, 0, 0);

        // BEQ not taken, then taken
        nx(); jump_inst_i = 0; branch_inst_i = 1; #1 idle("bnt_fw");
        nx(); #1 exp_o("bnt_e0", 1, 0, 1, PC_SEL_INC, 0, 0, 0, 0, 0);
        nx(); branch_taken_i = 1; #1 idle("bt_fw");
        nx(); #1 idle("bt_e0");
        nx(); #1 exp_o("bt_e1", 1, 0, 1, PC_SEL_ALU, 0, 1, 0, 0, 0);

        // Load, done in the 3rd wait cycle: req high 4 cycles
        nx(); branch_inst_i = 0; branch_taken_i = 0; lsu_r_en_i = 1; #1 idle("ld_fw");
        nx(); #1 exp_o("ld_e0", 0, 0, 0, PC_SEL_INC, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            nx(); #1 exp_o("ld_mw", 0, 0, 0, PC_SEL_INC, 1, 0, 0, 0, 0);
        end
        nx(); lsu_done_i = 1; #1 exp_o("ld_done", 1, 1, 1, PC_SEL_INC, 1, 0, 0, 0, 0);
        // done while no request is ignored; then same-cycle done in EXEC0
        nx(); #1 idle("done_ignored");
        nx(); #1 exp_o("ld_e0_done", 1, 1, 1, PC_SEL_INC, 1, 0, 0, 0, 0);

        // Store timeout: trap in the 4th wait cycle, cause 7
        nx(); lsu_done_i = 0; lsu_r_en_i = 0; lsu_w_en_i = 1; #1 idle("st_fw");
        nx(); #1 exp_o("st_e0", 0, 0, 0, PC_SEL_INC, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            nx(); #1 exp_o("st_mw", 0, 0, 0, PC_SEL_INC, 1, 0, 0, 0, 0);
        end
        nx(); #1 exp_o("st_to", 1, 0, 1, PC_SEL_TRAP, 0, 0, 1, 1, 32'd7);

        // Load timeout: cause 5
        nx(); lsu_w_en_i = 0; lsu_r_en_i = 1; #1 idle("ldto_fw");
        nx(); #1 exp_o("ldto_e0", 0, 0, 0, PC_SEL_INC, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            nx(); #1 exp_o("ldto_mw", 0, 0, 0, PC_SEL_INC, 1, 0, 0, 0, 0);
        end
        nx(); #1 exp_o("ldto_to", 1, 0, 1, PC_SEL_TRAP, 0, 0, 1, 1, 32'd5);

        // Store with done in the timeout cycle: done wins
        nx(); lsu_r_en_i = 0; lsu_w_en_i = 1; #1 idle("stw_fw");
        nx(); #1 exp_o("stw_e0", 0, 0, 0, PC_SEL_INC, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            nx(); #1 exp_o("stw_mw", 0, 0, 0, PC_SEL_INC, 1, 0, 0, 0, 0);
        end
        nx(); lsu_done_i = 1; #1 exp_o("stw_done", 1, 0, 1, PC_SEL_INC, 1, 0, 0, 0, 0);

        // Illegal beats rf_we and ECALL
        nx(); lsu_done_i = 0; lsu_w_en_i = 0; illegal_inst_i = 1; ecall_inst_i = 1; rf_we_i = 1;
        #1 idle("ill_fw");
        nx(); #1 exp_o("ill_e0", 1, 0, 1, PC_SEL_TRAP, 0, 0, 1, 1, 32'd2);
        nx(); illegal_inst_i = 0; #1 idle("ecall_fw");
        nx(); #1 exp_o("ecall_e0", 1, 0, 1, PC_SEL_TRAP, 0, 0, 1, 1, 32'd11);
        nx(); ecall_inst_i = 0; ebreak_inst_i = 1; #1 idle("ebrk_fw");
        nx(); #1 exp_o("ebrk_e0", 1, 0, 1, PC_SEL_TRAP, 0, 0, 1, 1, 32'd3);
        nx(); ebreak_inst_i = 0; rf_we_i = 0; mret_inst_i = 1; #1 idle("mret_fw");
        nx(); #1 exp_o("mret_e0", 1, 0, 1, PC_SEL_MEPC, 0, 0, 0, 0, 0);

`ifdef EXEC_IRQ_EN
        // Interrupt during a store: no request, instruction not retired
        nx(); mret_inst_i = 0; lsu_w_en_i = 1; irq_i = 1; mie_i = 1; #1 idle("irq_fw");
        nx(); #1 exp_o("irq_e0", 0, 0, 1, PC_SEL_TRAP, 0, 0, 1, 1, 32'h8000000B);
        nx(); mie_i = 0; #1 idle("irqm_fw");
        nx(); #1 exp_o("irqm_e0", 0, 0, 0, PC_SEL_INC, 1, 0, 0, 0, 0);
        nx(); lsu_done_i = 1; #1 exp_o("irqm_done", 1, 0, 1, PC_SEL_INC, 1, 0, 0, 0, 0);
        nx(); lsu_done_i = 0; irq_i = 0; lsu_w_en_i = 0;
`else
        nx(); mret_inst_i = 0;
`endif

        // Reset asserted in MEM_WAIT
        lsu_r_en_i = 1; #1 idle("rst_fw");
        nx(); #1 exp_o("rst_e0", 0, 0, 0, PC_SEL_INC, 1, 0, 0, 0, 0);
        nx(); #1 exp_o("rst_mw", 0, 0, 0, PC_SEL_INC, 1, 0, 0, 0, 0);
        rst_n = 1'b0; #1 idle("rst_async");
        chk("rst_async.state", 32'(dut.state_q), 32'(FETCH_WAIT));
        nx(); instr_valid_i = 0; rst_n = 1'b1; #1 idle("rst_rel");
        nx(); #1 idle("rst_hold");
        chk("rst_hold.state", 32'(dut.state_q), 32'(FETCH_WAIT));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
